timer_pulse_monitor: RTL and testbench

Sits on the output of the timer controller FSM, the Off/on1/on2/on3 one-shot driven by button b. It observes the timed output x and measures the width of every high pulse in clock cycles. It checks each width against the expected on-time and hands each measurement to a consumer over a valid/ready handshake with a one-entry result register. It is the checking end of the b→x timer interface, used in system self-test and as a bench scoreboard front-end.

---
 rtl/timer_pulse_monitor_if.sv | 28 ++
 rtl/timer_pulse_monitor.sv | 100 ++++++++++
 tb/tb_timer_pulse_monitor.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/timer_pulse_monitor_if.sv
// timer_pulse_monitor_if
//   Result handshake between the pulse monitor (master) and its consumer (slave).
//   out_valid : result register holds an unconsumed measurement
//   out_ready : consumer accepts the result at this edge
//   out_len   : measured high width in cycles (saturated)
//   out_err   : width differs from the expected on-time, or the counter saturated
interface timer_pulse_monitor_if #(
    parameter int unsigned CNT_W = 4
) ();
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] out_len;
    logic             out_err;

    modport master (
        output out_valid,
        output out_len,
        output out_err,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_len,
        input  out_err,
        output out_ready
    );
endinterface

// File: rtl/timer_pulse_monitor.sv
// timer_pulse_monitor
//   Measures the width of every high pulse on x (the timer one-shot output),
//   checks it against EXPECT_LEN and offers each result through a one-entry
//   valid/ready result register.
// Ports:
//   clk         : system clock, rising edge
//   rst_n       : synchronous active-low reset
//   x           : observed timer output, synchronous to clk
//   res         : result handshake (master side): out_valid/out_ready/out_len/out_err
//   overrun     : sticky, a completed pulse was dropped because the result was still held
//   pulse_count : completed pulses since reset, dropped ones included; wraps
module timer_pulse_monitor #(
    parameter int unsigned EXPECT_LEN = 3,
    parameter int unsigned CNT_W      = 4,
    parameter int unsigned PCNT_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  x,
    timer_pulse_monitor_if.master res,
    output logic                  overrun,
    output logic [PCNT_W-1:0]     pulse_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] EXP_LEN = CNT_W'(EXPECT_LEN);

    typedef enum logic [1:0] {
        DISARMED,
        IDLE,
        HIGH
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_valid;
    logic [CNT_W-1:0]    r_len;
    logic                r_err;
    logic                r_overrun;
    logic [PCNT_W-1:0]   r_pcnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= DISARMED;
            r_cnt     <= '0;
            r_valid   <= 1'b0;
            r_len     <= '0;
            r_err     <= 1'b0;
            r_overrun <= 1'b0;
            r_pcnt    <= '0;
        end else begin
            // Transfer clears the result; a completion below at the same edge overrides it.
            if (r_valid && res.out_ready) begin
                r_valid <= 1'b0;
            end

            case (r_state)
                DISARMED: begin
                    // A pulse already high at reset release is never measured.
                    if (!x) begin
                        r_state <= IDLE;
                    end
                end
                IDLE: begin
                    if (x) begin
                        r_state <= HIGH;
                        r_cnt   <= CNT_W'(1);
                    end
                end
                HIGH: begin
                    if (x) begin
                        if (r_cnt != CNT_MAX) begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end else begin
                        r_state <= IDLE;
                        r_pcnt  <= r_pcnt + 1'b1;
                        if (!r_valid || res.out_ready) begin
                            r_valid <= 1'b1;
                            r_len   <= r_cnt;
                            r_err   <= (r_cnt != EXP_LEN) || (r_cnt == CNT_MAX);
                        end else begin
                            r_overrun <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= DISARMED;
                end
            endcase
        end
    end

    assign res.out_valid = r_valid;
    assign res.out_len   = r_len;
    assign res.out_err   = r_err;
    assign overrun       = r_overrun;
    assign pulse_count   = r_pcnt;

endmodule

// File: tb/tb_timer_pulse_monitor.sv
// tb_timer_pulse_monitor
//   Directed scenarios followed by randomized pulse trains, every cycle checked
//   against a run-length reference model of the pulse monitor.
module tb_timer_pulse_monitor;

    localparam int unsigned EXPECT_LEN = 3;
    localparam int unsigned CNT_W      = 4;
    localparam int unsigned PCNT_W     = 8;
    localparam int          SAT        = (1 << CNT_W) - 1;

    logic              clk;
    logic              rst_n;
    logic              x;
    logic              overrun;
    logic [PCNT_W-1:0] pulse_count;

    timer_pulse_monitor_if #(.CNT_W(CNT_W)) bus ();

    timer_pulse_monitor #(
        .EXPECT_LEN (EXPECT_LEN),
        .CNT_W      (CNT_W),
        .PCNT_W     (PCNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .x           (x),
        .res         (bus.master),
        .overrun     (overrun),
        .pulse_count (pulse_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: armed flag, pulse-in-progress flag, unbounded run length.
    bit m_armed;
    bit m_inpulse;
    int m_run;
    bit m_valid;
    int m_len;
    bit m_err;
    bit m_ovr;
    int m_pc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit xv, input bit rdy, input bit rstv);
        int len;
        if (!rstv) begin
            m_armed = 0; m_inpulse = 0; m_run = 0;
            m_valid = 0; m_len = 0; m_err = 0; m_ovr = 0; m_pc = 0;
        end else begin
            if (m_valid && rdy) m_valid = 0;
            if (!m_armed) begin
                if (!xv) m_armed = 1;
            end else if (xv) begin
                if (m_inpulse) m_run = m_run + 1;
                else begin m_inpulse = 1; m_run = 1; end
            end else if (m_inpulse) begin
                m_inpulse = 0;
                m_pc = (m_pc + 1) % (1 << PCNT_W);
                len = (m_run > SAT) ? SAT : m_run;
                // a taken result has already cleared m_valid, so this covers reload too
                if (!m_valid) begin
                    m_valid = 1;
                    m_len   = len;
                    m_err   = (len != EXPECT_LEN) || (len == SAT);
                end else begin
                    m_ovr = 1;
                end
            end
        end
    endtask

    // One clock: apply inputs, advance model at the edge, check all outputs after it.
    task automatic cycle(input bit xv, input bit rdy, input bit rstv, input string tag);
        x             = xv;
        bus.out_ready = rdy;
        rst_n         = rstv;
        @(posedge clk);
        model_edge(xv, rdy, rstv);
        #1;
        chk({tag, ".valid"}, 32'(bus.out_valid), 32'(m_valid));
        chk({tag, ".len"},   32'(bus.out_len),   32'(m_len));
        chk({tag, ".err"},   32'(bus.out_err),   32'(m_err));
        chk({tag, ".ovr"},   32'(overrun),       32'(m_ovr));
        chk({tag, ".pc"},    32'(pulse_count),   32'(m_pc));
    endtask

    initial begin
        int hl;
        int ll;
        bit rdy;
        x = 1'b0;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        #2;

        // Reset state
        cycle(0, 1, 0, "rst");
        cycle(0, 1, 0, "rst");
        chk("rst_valid0", 32'(bus.out_valid), 0);
        chk("rst_pc0", 32'(pulse_count), 0);

        // 1: nominal 3-cycle pulse, result visible for exactly one cycle
        cycle(0, 1, 1, "t1");
        cycle(0, 1, 1, "t1");
        repeat (3) cycle(1, 1, 1, "t1");
        cycle(0, 1, 1, "t1");
        chk("t1_valid", 32'(bus.out_valid), 1);
        chk("t1_len", 32'(bus.out_len), 3);
        chk("t1_err", 32'(bus.out_err), 0);
        cycle(0, 1, 1, "t1");
        chk("t1_drop", 32'(bus.out_valid), 0);
        chk("t1_pc", 32'(pulse_count), 1);

        // 2: 1-cycle pulse, 1-cycle gap, 4-cycle pulse
        cycle(1, 1, 1, "t2");
        cycle(0, 1, 1, "t2");
        chk("t2_len1", 32'(bus.out_len), 1);
        chk("t2_err1", 32'(bus.out_err), 1);
        repeat (4) cycle(1, 1, 1, "t2");
        cycle(0, 1, 1, "t2");
        chk("t2_len4", 32'(bus.out_len), 4);
        chk("t2_err4", 32'(bus.out_err), 1);
        cycle(0, 1, 1, "t2");

        // 3: saturation
        repeat (20) cycle(1, 1, 1, "t3");
        cycle(0, 1, 1, "t3");
        chk("t3_len", 32'(bus.out_len), 15);
        chk("t3_err", 32'(bus.out_err), 1);
        cycle(0, 1, 1, "t3");

        // 4: result held, second pulse dropped
        repeat (3) cycle(1, 0, 1, "t4");
        cycle(0, 0, 1, "t4");
        repeat (2) cycle(1, 0, 1, "t4");
        cycle(0, 0, 1, "t4");
        chk("t4_len", 32'(bus.out_len), 3);
        chk("t4_ovr", 32'(overrun), 1);
        cycle(0, 1, 1, "t4");
        chk("t4_taken", 32'(bus.out_valid), 0);
        cycle(0, 0, 1, "t4");

        // 5: consume and reload at the same edge
        cycle(0, 0, 0, "t5");
        cycle(0, 0, 1, "t5");
        repeat (3) cycle(1, 0, 1, "t5");
        cycle(0, 0, 1, "t5");
        repeat (2) cycle(1, 0, 1, "t5");
        cycle(0, 1, 1, "t5");
        chk("t5_valid", 32'(bus.out_valid), 1);
        chk("t5_len", 32'(bus.out_len), 2);
        chk("t5_ovr", 32'(overrun), 0);
        cycle(0, 1, 1, "t5");

        // 6a: pulse already high at reset release is ignored
        cycle(1, 1, 0, "t6");
        repeat (2) cycle(1, 1, 1, "t6");
        cycle(0, 1, 1, "t6");
        chk("t6_nores", 32'(bus.out_valid), 0);
        repeat (3) cycle(1, 1, 1, "t6");
        cycle(0, 1, 1, "t6");
        chk("t6_len", 32'(bus.out_len), 3);
        chk("t6_pc", 32'(pulse_count), 1);
        // 6b: reset mid-pulse discards it
        cycle(1, 1, 1, "t6b");
        cycle(1, 1, 0, "t6b");
        cycle(1, 1, 1, "t6b");
        cycle(0, 1, 1, "t6b");
        chk("t6b_valid", 32'(bus.out_valid), 0);
        chk("t6b_pc", 32'(pulse_count), 0);

        // Randomized pulse trains with random back-pressure and rare resets
        for (int p = 0; p < 200; p++) begin
            hl = ($urandom_range(0, 9) == 0) ? 17 : int'($urandom_range(1, 5));
            ll = int'($urandom_range(1, 3));
            for (int i = 0; i < hl; i++) begin
                rdy = ($urandom_range(0, 3) != 0);
                cycle(1, rdy, ($urandom_range(0, 299) != 0), "rnd");
            end
            for (int i = 0; i < ll; i++) begin
                rdy = ($urandom_range(0, 3) != 0);
                cycle(0, rdy, ($urandom_range(0, 299) != 0), "rnd");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
